// File: rtl/mod_reg16_16to4_out.sv
// Output serializer for the AES256 core: captures a 16-byte block and emits it as four 32-bit words.
// Optional macro AES_OUT_DBUF_EN adds a pending block buffer so consecutive blocks stream with no bubble.
module mod_reg16_16to4_out #(
  parameter int N          = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N-1:0][7:0] i,
  input  logic            i_valid,
  output logic            i_ready,
  output logic [31:0]     o,
  output logic            o_valid,
  input  logic            o_ready,
  output logic            o_last,
  output logic            busy
);

  localparam int NWORDS = N / WORD_BYTES;
  localparam logic [1:0] LAST_WORD = 2'(NWORDS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state;
  logic [N-1:0][7:0] blk;
  logic [1:0]        n_rd;
  logic              accept;
  logic              xfer;
  logic              last_xfer;

  // Word w packs bytes 4w..4w+3 with the lowest-numbered byte in the low lane.
  function automatic logic [31:0] word_of(input logic [N-1:0][7:0] b, input logic [1:0] w);
    logic [N*8-1:0] flat;
    flat = b;
    return flat[{w, 5'b0} +: 32];
  endfunction

  assign accept    = i_valid && i_ready;
  assign xfer      = o_valid && o_ready;
  assign last_xfer = xfer && (n_rd == LAST_WORD);

`ifdef AES_OUT_DBUF_EN
  logic [N-1:0][7:0] pend_blk;
  logic              pend_full;

  assign i_ready = !pend_full;
`else
  assign i_ready = (state == IDLE);
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      blk     <= '0;
      n_rd    <= 2'd0;
      o       <= 32'd0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      busy    <= 1'b0;
`ifdef AES_OUT_DBUF_EN
      pend_blk  <= '0;
      pend_full <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            blk     <= i;
            o       <= word_of(i, 2'd0);
            o_valid <= 1'b1;
            o_last  <= 1'b0;
            busy    <= 1'b1;
            n_rd    <= 2'd0;
            state   <= SEND;
          end
        end
        SEND: begin
          if (xfer && !last_xfer) begin
            n_rd   <= n_rd + 2'd1;
            o      <= word_of(blk, n_rd + 2'd1);
            o_last <= ((n_rd + 2'd1) == LAST_WORD);
          end else if (last_xfer) begin
            n_rd   <= 2'd0;
            o_last <= 1'b0;
`ifdef AES_OUT_DBUF_EN
            // A waiting block (buffered or arriving now) takes over without dropping o_valid.
            if (pend_full) begin
              blk <= pend_blk;
              o   <= word_of(pend_blk, 2'd0);
            end else if (accept) begin
              blk <= i;
              o   <= word_of(i, 2'd0);
            end else begin
              o_valid <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
`else
            o_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
`endif
          end
`ifdef AES_OUT_DBUF_EN
          if (last_xfer) begin
            pend_full <= 1'b0;
          end else if (accept) begin
            pend_blk  <= i;
            pend_full <= 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reg16_16to4_out.sv
// Scoreboard bench for mod_reg16_16to4_out: expected words are queued on block acceptance and
// checked by an independent monitor on every word transfer.
module tb_mod_reg16_16to4_out;

  logic             clk = 1'b0;
  logic             resetn = 1'b1;
  logic [15:0][7:0] i = '0;
  logic             i_valid = 1'b0;
  logic             i_ready;
  logic [31:0]      o;
  logic             o_valid;
  logic             o_ready = 1'b0;
  logic             o_last;
  logic             busy;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] sb[$];
  logic        stall_seen = 1'b0;
  logic [31:0] stall_o = '0;
  logic        stall_last = 1'b0;
  logic [32:0] exp_word;

  mod_reg16_16to4_out dut (
    .clk     (clk),
    .resetn  (resetn),
    .i       (i),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o       (o),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .o_last  (o_last),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: every transfer pops one expected word; a stalled word must be unchanged next cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checkOutput("stall_hold_o", o, stall_o);
        checkFlag("stall_hold_last", o_last, stall_last);
        checkFlag("stall_hold_valid", o_valid, 1'b1);
      end
      if (o_valid && o_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_word: got 0x%08h, expected no transfer", o);
        end else begin
          exp_word = sb.pop_front();
          checkOutput("word", o, exp_word[31:0]);
          checkFlag("word_last", o_last, exp_word[32]);
        end
      end
      stall_seen = o_valid && !o_ready;
      stall_o    = o;
      stall_last = o_last;
    end
  end

  // Offers a block with byte k = base + k, waits for acceptance, then queues its four words.
  task automatic applyStimulus(input logic [7:0] base, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] w2, input logic [31:0] w3);
    int cyc;
    for (int k = 0; k < 16; k++) i[k] = base + 8'(k);
    i_valid = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (!i_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!i_ready) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got i_ready=0, expected 1 within 100 cycles");
      @(posedge clk);
      #1 i_valid = 1'b0;
    end else begin
      sb.push_back({1'b0, w0});
      sb.push_back({1'b0, w1});
      sb.push_back({1'b0, w2});
      sb.push_back({1'b1, w3});
      @(posedge clk);
      #1 i_valid = 1'b0;
    end
  endtask

  task automatic waitDrain();
    int cyc;
    cyc = 0;
    o_ready = 1'b1;
    while ((sb.size() != 0 || o_valid) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb.size() != 0 || o_valid) begin
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d words pending, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #1 resetn = 1'b0;
    #2;
    checkOutput("reset_o", o, 32'd0);
    checkFlag("reset_o_valid", o_valid, 1'b0);
    checkFlag("reset_o_last", o_last, 1'b0);
    checkFlag("reset_busy", busy, 1'b0);
    checkFlag("reset_i_ready", i_ready, 1'b1);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: streaming block 0x00..0x0F with o_ready held high
    $display("[TB] test 1: basic block");
    o_ready = 1'b1;
    applyStimulus(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    checkFlag("lat_o_valid", o_valid, 1'b1);
    checkOutput("lat_word0", o, 32'h03020100);
    checkFlag("lat_busy", busy, 1'b1);
    checkFlag("lat_o_last", o_last, 1'b0);
`ifndef AES_OUT_DBUF_EN
    checkFlag("send_i_ready", i_ready, 1'b0);
`endif
    waitDrain();
    checkFlag("done_o_valid", o_valid, 1'b0);
    checkFlag("done_i_ready", i_ready, 1'b1);
    checkFlag("done_busy", busy, 1'b0);
    checkFlag("done_o_last", o_last, 1'b0);

    // 2: back-pressure pattern on o_ready
    $display("[TB] test 2: stalls");
    begin
      logic pat[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      o_ready = 1'b0;
      applyStimulus(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
      for (int k = 0; k < 12; k++) begin
        o_ready = pat[k];
        @(posedge clk);
        #1;
      end
    end
    waitDrain();

    // 3: second block offered while the first is still being sent
    $display("[TB] test 3: block offered during send");
    o_ready = 1'b1;
    applyStimulus(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
`ifndef AES_OUT_DBUF_EN
    for (int k = 0; k < 16; k++) i[k] = 8'hF0 + 8'(k);
    i_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkFlag("hold_i_ready", i_ready, 1'b0);
      checkFlag("hold_busy", busy, 1'b1);
    end
`endif
    applyStimulus(8'hF0, 32'hF3F2F1F0, 32'hF7F6F5F4, 32'hFBFAF9F8, 32'hFFFEFDFC);
    waitDrain();

    // 4: asynchronous reset after word 1 has transferred
    $display("[TB] test 4: mid-block reset");
    o_ready = 1'b1;
    applyStimulus(8'h20, 32'h23222120, 32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C);
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    sb.delete();
    #1;
    checkFlag("abort_o_valid", o_valid, 1'b0);
    checkOutput("abort_o", o, 32'd0);
    checkFlag("abort_busy", busy, 1'b0);
    checkFlag("abort_i_ready", i_ready, 1'b1);
    checkFlag("abort_o_last", o_last, 1'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkFlag("post_reset_o_valid", o_valid, 1'b0);
    end
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    checkOutput("restart_word0", o, 32'h03020100);
    waitDrain();

    // 5: idle with o_ready high and no block offered
    $display("[TB] test 5: idle");
    o_ready = 1'b1;
    i_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checkFlag("idle_o_valid", o_valid, 1'b0);
    end
    @(posedge clk);
    #1;

`ifdef AES_OUT_DBUF_EN
    // 6: two blocks back to back through the pending buffer
    $display("[TB] test 6: double buffer");
    o_ready = 1'b1;
    applyStimulus(8'h00, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C);
    fork
      applyStimulus(8'h10, 32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C);
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          checkFlag("dbuf_no_gap", o_valid, 1'b1);
          checkFlag("dbuf_last", o_last, (k == 3 || k == 7));
          if (k == 4) checkOutput("dbuf_word5", o, 32'h13121110);
        end
      end
    join
    waitDrain();
`endif

    o_ready = 1'b0;
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
